// File: rtl/acq_sequencer_pkg.sv
// Shared types and constants for the acquisition sequencer: state encoding,
// trigger mode codes and the default frame geometry.
package acq_sequencer_pkg;

    localparam int SCREEN_W = 640;
    localparam int ADDR_W   = 10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_READY   = 3'd3,
        ST_HOLDOFF = 3'd4
    } acq_state_e;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;
    localparam logic [1:0] MODE_STOP   = 2'b11;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/acq_sequencer_strobe_counter.sv
// Sample-strobe counter: advances only on enabled strobes, saturates at its
// terminal value and flags when that value has been reached.
module strobe_counter #(
    parameter int WIDTH    = 10,
    parameter int TERMINAL = 639
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             stb_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i && stb_i && (count_q != TC))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == TC);

endmodule

// File: rtl/acq_sequencer.sv
// Oscilloscope acquisition sequencer: arms on mode/arm, captures one frame of
// SCREEN_W samples after a trigger or auto timeout, hands it to the display.
module acq_sequencer #(
    parameter int SCREEN_W     = acq_sequencer_pkg::SCREEN_W,
    parameter int AUTO_TIMEOUT = 640,
    parameter int HOLDOFF      = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sample_en,
    input  logic [1:0]                        mode,
    input  logic                              trig_in,
    input  logic                              arm,
    input  logic                              frame_ack,
    output logic                              wr_en,
    output logic [acq_sequencer_pkg::ADDR_W-1:0] wr_addr,
    output logic                              frame_ready,
    output logic                              auto_fired,
    output logic [2:0]                        state_o
);

    import acq_sequencer_pkg::*;

    localparam int TO_W = cnt_width(AUTO_TIMEOUT);
    localparam int HO_W = cnt_width(HOLDOFF);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(SCREEN_W - 1);

    acq_state_e        state_q;
    logic [1:0]        mode_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              frame_ready_q;
    logic              auto_q;

    logic [ADDR_W-1:0] col_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [HO_W-1:0]   ho_cnt;
    logic              col_tc, to_tc, ho_tc;

    logic stop, trig_hit, to_hit, start, last_done;
    logic col_clr, col_en, to_clr, to_en, ho_clr;

    assign stop      = (mode == MODE_STOP);
    assign trig_hit  = (state_q == ST_ARMED) && !stop && sample_en && trig_in;
    assign to_hit    = (state_q == ST_ARMED) && !stop && sample_en &&
                       (mode_q == MODE_AUTO) && to_tc;
    assign start     = trig_hit || to_hit;
    // The final column was written last cycle; the frame is complete.
    assign last_done = wr_en_q && (wr_addr_q == LAST_COL);

    assign col_clr = (state_q != ST_CAPTURE) && !start;
    assign col_en  = start || ((state_q == ST_CAPTURE) && !last_done);
    assign to_clr  = (state_q != ST_ARMED) || start;
    assign to_en   = (state_q == ST_ARMED) && (mode_q == MODE_AUTO);
    assign ho_clr  = (state_q != ST_HOLDOFF);

    // Column counter holds the next address; the capture-starting strobe
    // takes column 0 so it leaves the counter at 1.
    strobe_counter #(
        .WIDTH    (ADDR_W),
        .TERMINAL (SCREEN_W - 1)
    ) u_col_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (col_clr),
        .en_i    (col_en),
        .stb_i   (sample_en),
        .count_o (col_cnt),
        .tc_o    (col_tc)
    );

    strobe_counter #(
        .WIDTH    (TO_W),
        .TERMINAL (AUTO_TIMEOUT - 1)
    ) u_to_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (to_clr),
        .en_i    (to_en),
        .stb_i   (sample_en),
        .count_o (to_cnt),
        .tc_o    (to_tc)
    );

    strobe_counter #(
        .WIDTH    (HO_W),
        .TERMINAL (HOLDOFF - 1)
    ) u_ho_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (ho_clr),
        .en_i    (1'b1),
        .stb_i   (sample_en),
        .count_o (ho_cnt),
        .tc_o    (ho_tc)
    );

    logic unused_cnt;
    assign unused_cnt = ^{to_cnt, ho_cnt, col_tc};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_NORMAL;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            frame_ready_q <= 1'b0;
            auto_q        <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // Mode is sampled here and held for the whole acquisition.
                    if ((mode == MODE_NORMAL) || (mode == MODE_AUTO) ||
                        ((mode == MODE_SINGLE) && arm)) begin
                        state_q <= ST_ARMED;
                        mode_q  <= mode;
                    end
                end
                ST_ARMED: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        state_q   <= ST_CAPTURE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        auto_q    <= !trig_hit;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (last_done) begin
                        state_q       <= ST_READY;
                        frame_ready_q <= 1'b1;
                    end else if (sample_en) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= col_cnt;
                    end
                end
                ST_READY: begin
                    if (frame_ack) begin
                        state_q       <= ST_HOLDOFF;
                        frame_ready_q <= 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    if (stop || (sample_en && ho_tc))
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign frame_ready = frame_ready_q;
    assign auto_fired  = auto_q;
    assign state_o     = state_q;

endmodule
